// File: rtl/cic_decimator.sv
// CIC decimation filter: N pipelined integrators at the input rate, decimate by RATE,
// then N comb stages (differential delay DIFF_DELAY) at the output rate. Full precision.
module cic_decimator #(
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned N_STAGES   = 4,
  parameter int unsigned RATE       = 16,
  parameter int unsigned DIFF_DELAY = 1,
  localparam int unsigned ACC_W     = IN_WIDTH + N_STAGES * $clog2(RATE * DIFF_DELAY)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [IN_WIDTH-1:0] in_data,
  output logic                       out_valid,
  output logic signed [ACC_W-1:0]    out_data
);

  localparam int unsigned CNT_W = $clog2(RATE);

  logic signed [ACC_W-1:0] integ    [N_STAGES];
  logic signed [ACC_W-1:0] comb     [N_STAGES];
  logic signed [ACC_W-1:0] dly      [N_STAGES][DIFF_DELAY];
  logic signed [ACC_W-1:0] comb_in  [N_STAGES];
  logic [N_STAGES-1:0]     stage_en;
  logic [N_STAGES-1:0]     vld;
  logic [CNT_W-1:0]        cnt;
  logic                    dec_stb;

  // Comb stage inputs: stage 0 takes the last integrator on the decimation strobe.
  always_comb begin
    comb_in[0]  = integ[N_STAGES-1];
    stage_en[0] = dec_stb;
    for (int k = 1; k < int'(N_STAGES); k++) begin
      comb_in[k]  = comb[k-1];
      stage_en[k] = vld[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      dec_stb <= 1'b0;
      vld     <= '0;
      for (int k = 0; k < int'(N_STAGES); k++) begin
        integ[k] <= '0;
        comb[k]  <= '0;
        for (int j = 0; j < int'(DIFF_DELAY); j++) begin
          dly[k][j] <= '0;
        end
      end
    end else begin
      // Integrators wrap modulo 2^ACC_W; each stage adds the previous stage's old value.
      if (in_valid) begin
        integ[0] <= integ[0] + ACC_W'(in_data);
        for (int k = 1; k < int'(N_STAGES); k++) begin
          integ[k] <= integ[k] + integ[k-1];
        end
        if (cnt == CNT_W'(RATE - 1)) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      dec_stb <= in_valid && (cnt == CNT_W'(RATE - 1));
      vld     <= stage_en;

      for (int k = 0; k < int'(N_STAGES); k++) begin
        if (stage_en[k]) begin
          comb[k]   <= comb_in[k] - dly[k][DIFF_DELAY-1];
          dly[k][0] <= comb_in[k];
          for (int j = 1; j < int'(DIFF_DELAY); j++) begin
            dly[k][j] <= dly[k][j-1];
          end
        end
      end
    end
  end

  assign out_valid = vld[N_STAGES-1];
  assign out_data  = comb[N_STAGES-1];

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: default instance and a (N=1, R=4, M=2) instance
// share stimulus; expected outputs come from an FIR-equivalent model of the CIC response.
module tb_cic_decimator;

  localparam int N0 = 4;
  localparam int R0 = 16;
  localparam int M0 = 1;
  localparam int W0 = 16 + N0 * $clog2(R0 * M0);
  localparam int N1 = 1;
  localparam int R1 = 4;
  localparam int M1 = 2;
  localparam int W1 = 16 + N1 * $clog2(R1 * M1);

  typedef struct {
    longint val;
    longint at;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [15:0]   in_data = '0;
  logic                 out_valid0;
  logic signed [W0-1:0] out_data0;
  logic                 out_valid1;
  logic signed [W1-1:0] out_data1;

  exp_t   q0[$];
  exp_t   q1[$];
  exp_t   e0;
  exp_t   e1;
  longint hist[$];
  int     cnt0 = 0;
  int     cnt1 = 0;
  longint cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  longint last0 = 0;
  longint last1 = 0;
  longint imp_sum = 0;
  bit     imp_on = 1'b0;

  cic_decimator dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid0), .out_data(out_data0)
  );

  cic_decimator #(.IN_WIDTH(16), .N_STAGES(N1), .RATE(R1), .DIFF_DELAY(M1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid1), .out_data(out_data1)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Impulse response is the N-fold self-convolution of a length R*M boxcar; the
  // pipelined integrators add N-1 samples of delay.
  function automatic longint model(input int n_st, input int r, input int m);
    longint h[];
    longint t[];
    longint y;
    int     n;
    int     idx;
    h = new[1];
    h[0] = 1;
    for (int s = 0; s < n_st; s++) begin
      t = new[h.size() + r * m - 1];
      for (int i = 0; i < h.size(); i++)
        for (int j = 0; j < r * m; j++)
          t[i+j] += h[i];
      h = t;
    end
    y = 0;
    n = hist.size();
    for (int i = 0; i < h.size(); i++) begin
      idx = n - 1 - (n_st - 1) - i;
      if (idx >= 0) y += h[i] * hist[idx];
    end
    return y;
  endfunction

  task automatic accept(input logic signed [15:0] d);
    exp_t tmp;
    hist.push_back(longint'(d));
    cnt0++;
    if (cnt0 == R0) begin
      cnt0 = 0;
      tmp.val = model(N0, R0, M0);
      tmp.at  = cyc + 1 + N0;
      q0.push_back(tmp);
    end
    cnt1++;
    if (cnt1 == R1) begin
      cnt1 = 0;
      tmp.val = model(N1, R1, M1);
      tmp.at  = cyc + 1 + N1;
      q1.push_back(tmp);
    end
  endtask

  task automatic send(input bit v, input logic signed [15:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    if (v) accept(d);
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 16'($urandom));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid0"}, longint'(out_valid0), 0);
    check({tag, "_data0"}, longint'(out_data0), 0);
    check({tag, "_valid1"}, longint'(out_valid1), 0);
    check({tag, "_data1"}, longint'(out_data1), 0);
  endtask

  // Drains pending outputs, then holds rst for n cycles with random inputs.
  task automatic do_reset(input int n);
    idle(N0 + 4);
    check("drain0", longint'(q0.size()), 0);
    check("drain1", longint'(q1.size()), 0);
    q0.delete();
    q1.delete();
    hist.delete();
    cnt0 = 0;
    cnt1 = 0;
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'($urandom);
    in_data  = 16'($urandom);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_zero("rst");
      if (i < n - 1) begin
        in_valid = 1'($urandom);
        in_data  = 16'($urandom);
      end else begin
        rst      = 1'b0;
        in_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_zero("post_rst");
  endtask

  // Scoreboard: every out_valid pops one expected value and its due cycle.
  always @(negedge clk) begin
    if (out_valid0 === 1'b1) begin
      if (q0.size() == 0) begin
        check("unexpected_valid0", 1, 0);
      end else begin
        e0 = q0.pop_front();
        check("data0", longint'(out_data0), e0.val);
        check("latency0", cyc, e0.at);
        last0 = longint'(out_data0);
        if (imp_on) imp_sum += longint'(out_data0);
      end
    end
    if (out_valid1 === 1'b1) begin
      if (q1.size() == 0) begin
        check("unexpected_valid1", 1, 0);
      end else begin
        e1 = q1.pop_front();
        check("data1", longint'(out_data1), e1.val);
        check("latency1", cyc, e1.at);
        last1 = longint'(out_data1);
      end
    end
  end

  initial begin
    int sent;
    bit v;

    do_reset(3);

    // DC gain
    repeat (8 * R0) send(1'b1, 16'sd1);
    idle(N0 + 3);
    check("dc_gain0", last0, 65536);
    check("dc_gain1", last1, 8);

    // Full-scale negative then positive, exercising integrator wrap
    repeat (8 * R0) send(1'b1, -16'sd32768);
    idle(N0 + 3);
    check("fullscale_neg", last0, -64'sd2147483648);
    repeat (8 * R0) send(1'b1, 16'sd32767);
    idle(N0 + 3);
    check("fullscale_pos", last0, 64'sd2147418112);

    // Impulse: decimation keeps one polyphase branch, whose taps sum to R^(N-1)
    do_reset(2);
    imp_on  = 1'b1;
    imp_sum = 0;
    send(1'b1, 16'sd1);
    repeat (8 * R0 - 1) send(1'b1, 16'sd0);
    idle(N0 + 3);
    imp_on = 1'b0;
    check("impulse_sum", imp_sum, longint'(R0) ** (N0 - 1));
    check("impulse_tail", last0, 0);

    // Gapped DC input
    do_reset(2);
    sent = 0;
    while (sent < 8 * R0) begin
      v = 1'($urandom);
      send(v, 16'sd1);
      if (v) sent++;
    end
    idle(N0 + 3);
    check("gapped_dc", last0, 65536);

    // Mid-block reset, then random data with gaps
    do_reset(1);
    repeat (7) send(1'b1, 16'($urandom));
    do_reset(1);
    repeat (R0) send(1'b1, 16'($urandom));
    for (int i = 0; i < 6 * R0; i++) send(1'($urandom), 16'($urandom));
    idle(N0 + 4);
    check("final_drain0", longint'(q0.size()), 0);
    check("final_drain1", longint'(q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
